// File: rtl/ram32_fifo_ctrl_pkg.sv
// Shared RAM32 constants: macro geometry plus the FIFO depth, pointer and
// occupancy widths derived from it.
package ram32_fifo_ctrl_pkg;

  localparam int RAM32_DEPTH    = 32;
  localparam int RAM32_AW       = 5;
  localparam int RAM32_DW       = 32;
  localparam int RAM32_WE_W     = 4;

  localparam int FIFO_DEPTH     = RAM32_DEPTH;
  localparam int FIFO_PTR_W     = RAM32_AW;
  localparam int FIFO_CNT_W     = RAM32_AW + 1;
  localparam int FIFO_AFULL_LVL = 28;

endpackage

// File: rtl/ram32_fifo_ctrl.sv
// FIFO controller for an externally instantiated RAM32_1RW1R macro.
// Port 0 writes at the write pointer; port 1 reads asynchronously at the read pointer.
module ram32_fifo_ctrl
  import ram32_fifo_ctrl_pkg::*;
#(
  parameter int data_w    = RAM32_DW,
  parameter int addr_w    = RAM32_AW,
  parameter int AFULL_LVL = FIFO_AFULL_LVL
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FLUSH,
  input  logic                  PUSH_VALID,
  input  logic [data_w-1:0]     PUSH_DATA,
  output logic                  PUSH_READY,
  output logic                  POP_VALID,
  output logic [data_w-1:0]     POP_DATA,
  input  logic                  POP_READY,
  output logic [addr_w:0]       COUNT,
  output logic                  AFULL,
  output logic                  RAM_EN0,
  output logic [addr_w-1:0]     RAM_A0,
  output logic [RAM32_WE_W-1:0] RAM_WE0,
  output logic [data_w-1:0]     RAM_DI0,
  output logic                  RAM_EN1,
  output logic [addr_w-1:0]     RAM_A1,
  input  logic [data_w-1:0]     RAM_DO1
);

  localparam logic [addr_w:0]   DEPTH_C = (addr_w+1)'(1 << addr_w);
  localparam logic [addr_w:0]   AFULL_C = (addr_w+1)'(AFULL_LVL);
  localparam logic [addr_w-1:0] PTR_ONE = addr_w'(1);
  localparam logic [addr_w:0]   CNT_ONE = (addr_w+1)'(1);

  logic [addr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_w:0]   count_q, count_d;
  logic              push;
  logic              pop;

  // No push while full, even alongside a pop: the slot frees only after the edge.
  assign PUSH_READY = (count_q != DEPTH_C) & ~FLUSH & ~RST;
  assign POP_VALID  = (count_q != '0);
  assign POP_DATA   = RAM_DO1;
  assign COUNT      = count_q;
  assign AFULL      = (count_q >= AFULL_C);

  assign push = PUSH_VALID & PUSH_READY;
  assign pop  = POP_VALID & POP_READY;

  assign RAM_EN0 = push;
  assign RAM_WE0 = {RAM32_WE_W{push}};
  assign RAM_DI0 = PUSH_DATA;
  assign RAM_A0  = wr_ptr_q;
  assign RAM_EN1 = 1'b1;
  assign RAM_A1  = rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Flush discards any concurrent pop; push cannot occur then since PUSH_READY is low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (FLUSH) begin
      rd_ptr_q <= wr_ptr_q;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_ram32_fifo_ctrl.sv
// Self-checking bench: behavioural RAM plus a queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_ram32_fifo_ctrl;

  logic        CLK = 1'b0;
  logic        RST, FLUSH, PUSH_VALID, POP_READY;
  logic [31:0] PUSH_DATA;
  logic        PUSH_READY, POP_VALID, AFULL, RAM_EN0, RAM_EN1;
  logic [31:0] POP_DATA, RAM_DI0, RAM_DO1;
  logic [5:0]  COUNT;
  logic [4:0]  RAM_A0, RAM_A1;
  logic [3:0]  RAM_WE0;

  logic [31:0] mem [32];
  logic [31:0] modelQ [$];
  int          wrAddr = 0;
  int          rdAddr = 0;
  int          total = 0;
  int          bad = 0;

  ram32_fifo_ctrl dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .PUSH_VALID(PUSH_VALID), .PUSH_DATA(PUSH_DATA), .PUSH_READY(PUSH_READY),
    .POP_VALID(POP_VALID), .POP_DATA(POP_DATA), .POP_READY(POP_READY),
    .COUNT(COUNT), .AFULL(AFULL),
    .RAM_EN0(RAM_EN0), .RAM_A0(RAM_A0), .RAM_WE0(RAM_WE0), .RAM_DI0(RAM_DI0),
    .RAM_EN1(RAM_EN1), .RAM_A1(RAM_A1), .RAM_DO1(RAM_DO1)
  );

  always #5 CLK = ~CLK;

  // Byte-enabled synchronous write port, asynchronous read port; preloaded with junk.
  initial for (int i = 0; i < 32; i++) mem[i] <= 32'hDEAD_0000 | i;
  always @(posedge CLK) begin
    for (int b = 0; b < 4; b++)
      if (RAM_EN0 && RAM_WE0[b]) mem[RAM_A0][8*b +: 8] <= RAM_DI0[8*b +: 8];
  end
  assign RAM_DO1 = mem[RAM_A1];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs at the falling edge, advance the model at the rising edge.
  task automatic applyStimulus(input logic pv, input logic [31:0] pd, input logic pr,
                               input logic fl, input logic rs);
    int   n;
    logic expReady, expPush, expPop;
    PUSH_VALID = pv;
    PUSH_DATA  = pd;
    POP_READY  = pr;
    FLUSH      = fl;
    RST        = rs;
    @(negedge CLK);
    n        = modelQ.size();
    expReady = (n != 32) && !fl && !rs;
    expPush  = pv && expReady;
    expPop   = (n != 0) && pr;
    checkOutput("push_ready", PUSH_READY, expReady);
    checkOutput("pop_valid", POP_VALID, n != 0);
    checkOutput("count", COUNT, n);
    checkOutput("afull", AFULL, n >= 28);
    checkOutput("ram_en0", RAM_EN0, expPush);
    checkOutput("ram_we0", RAM_WE0, {4{expPush}});
    checkOutput("ram_di0", RAM_DI0, pd);
    checkOutput("ram_a0", RAM_A0, wrAddr);
    checkOutput("ram_a1", RAM_A1, rdAddr);
    checkOutput("ram_en1", RAM_EN1, 1'b1);
    if (n != 0) checkOutput("pop_data", POP_DATA, modelQ[0]);
    @(posedge CLK);
    if (rs) begin
      modelQ.delete();
      wrAddr = 0;
      rdAddr = 0;
    end else if (fl) begin
      modelQ.delete();
      rdAddr = wrAddr;
    end else begin
      if (expPop) begin
        void'(modelQ.pop_front());
        rdAddr = (rdAddr + 1) % 32;
      end
      if (expPush) begin
        modelQ.push_back(pd);
        wrAddr = (wrAddr + 1) % 32;
      end
    end
    #1;
  endtask

  initial begin
    // Reset, then a single push visible one cycle later
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Fill with 0..31, attempt a 33rd push, then drain and pop once more while empty
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, i, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 33; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Continuous overlapped push/pop of 40 words across pointer wrap
    applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 39; i++) applyStimulus(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Full FIFO with push and pop together, then a push that fits again
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h8765_4321, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Flush at COUNT=5 with pop and push requested, then a fresh word
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hFFFF_0000, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Reset at COUNT=10 with a push pending; next push lands at address 0
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h600D_0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic: push-heavy, then pop-heavy, with occasional flush/reset
    for (int i = 0; i < 300; i++) begin
      int pushPct;
      pushPct = (i < 150) ? 80 : 30;
      applyStimulus($urandom_range(0, 99) < pushPct, $urandom,
                    $urandom_range(0, 99) < (100 - pushPct),
                    $urandom_range(0, 39) == 0, $urandom_range(0, 79) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram32_fifo_ctrl.md
RAM32_FIFO_CTRL -- requirements
Module: ram32_fifo_ctrl

Interface
REQ-001 Parameters: data_w, default 32, entry width; addr_w, default 5, pointer width (depth 2**addr_w = 32); AFULL_LVL, default 28, almost-full threshold in entries.
REQ-002 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 FLUSH  input  1  synchronous empty request.
REQ-005 PUSH_VALID  input  1  producer has data on PUSH_DATA.
REQ-006 PUSH_DATA  input  data_w  write data.
REQ-007 PUSH_READY  output  1  FIFO accepts a write this cycle.
REQ-008 POP_VALID  output  1  POP_DATA holds the oldest entry.
REQ-009 POP_DATA  output  data_w  oldest entry.
REQ-010 POP_READY  input  1  consumer takes the entry this cycle.
REQ-011 COUNT  output  addr_w+1  occupancy, 0..32.
REQ-012 AFULL  output  1  COUNT >= AFULL_LVL.
REQ-013 RAM_EN0  output  1  drives RAM port-0 enable.
REQ-014 RAM_A0  output  addr_w  drives RAM port-0 address (write pointer).
REQ-015 RAM_WE0  output  4  drives RAM byte write enables.
REQ-016 RAM_DI0  output  data_w  drives RAM write data.
REQ-017 RAM_EN1  output  1  drives RAM port-1 enable; tied 1.
REQ-018 RAM_A1  output  addr_w  drives RAM port-1 address (read pointer).
REQ-019 RAM_DO1  input  data_w  RAM port-1 read data, combinational from RAM_A1 (RAM built with USE_LATCH=0).

Function
REQ-020 push = PUSH_VALID & PUSH_READY; pop = POP_VALID & POP_READY; each is a transfer in that cycle.
REQ-021 PUSH_READY SHALL equal (COUNT != 32) & !FLUSH & !RST; no push-while-full bypass, even with simultaneous pop.
REQ-022 POP_VALID SHALL equal (COUNT != 0); POP_DATA SHALL equal RAM_DO1 combinationally.
REQ-023 RAM_EN0 = push, RAM_WE0 = {4{push}}, RAM_DI0 = PUSH_DATA, RAM_A0 = wr_ptr, RAM_A1 = rd_ptr, all combinational.
REQ-024 On push, wr_ptr SHALL increment by 1 modulo 32 (31 wraps to 0); on pop, rd_ptr likewise.
REQ-025 COUNT SHALL go +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-026 Latency: a word pushed at edge N SHALL be visible on POP_DATA with POP_VALID=1 in cycle N+1 if the FIFO was empty.
REQ-027 Simultaneous push and pop with COUNT=1 SHALL pop the old word and leave the new word at head; COUNT stays 1.
REQ-028 Pop with POP_VALID=0 and push with PUSH_READY=0 SHALL be ignored with no state change.
REQ-029 FLUSH SHALL, at the next edge, set rd_ptr := wr_ptr and COUNT := 0; any pop that cycle is discarded; no RAM write occurs that cycle.
REQ-030 POP_DATA SHALL hold steady while POP_VALID=1 and POP_READY=0.

Reset
REQ-031 RST SHALL, at the next posedge, set wr_ptr=0, rd_ptr=0, COUNT=0; thus POP_VALID=0, AFULL=0, PUSH_READY=1 after release.
REQ-032 RST SHALL take priority over FLUSH, push and pop; RAM contents are not cleared and no RAM write occurs while RST=1.
REQ-033 RST asserted mid-stream SHALL drop all queued entries; first post-reset push lands at address 0.

Structure
REQ-034 Depth, pointer width and occupancy width constants SHALL live in the shared RAM package alongside the RAM32 size constants.
REQ-035 Block is pure control; the RAM32_1RW1R macro SHALL be instantiated by the parent, not inside this module; no sub-module.

Verification
REQ-036 Reset, push 0xA5A5_0001 one cycle -> next cycle POP_VALID=1, POP_DATA=0xA5A5_0001, COUNT=1, RAM_A0 was 0.
REQ-037 Push 32 words 0..31 without pop -> COUNT=32, PUSH_READY=0, AFULL=1 from COUNT=28; 33rd push ignored; drain returns 0..31 in order.
REQ-038 Push 40 / pop 40 interleaved continuously -> pointers wrap 31->0, data in order, COUNT constant during overlap.
REQ-039 Full FIFO, PUSH_VALID=1 and pop same cycle -> COUNT=31 after edge, no write; next cycle push accepted, COUNT=32.
REQ-040 COUNT=5, assert FLUSH with POP_READY=1 -> COUNT=0, POP_VALID=0 next cycle; next push readable correctly.
REQ-041 COUNT=10, assert RST one cycle with PUSH_VALID=1 -> COUNT=0, no RAM_EN0 that cycle; next push uses RAM_A0=0.
